// File: rtl/vga_timing_generator.sv
// VGA timing generator: programmable hsync/vsync timing with a valid/ready pixel
// stream, registered video outputs, and a sticky underflow flag.
module vga_timing_generator #(
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 11,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 31
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic        en,
  input  logic [23:0] pix_rgb,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start,
  output logic        underflow,
  input  logic        underflow_clr
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

  if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_total_check
    $error("vga_timing_generator: H_TOTAL and V_TOTAL must not exceed 2047");
  end
  if (H_ACT == 0 || H_SYNC == 0 || V_ACT == 0 || V_SYNC == 0) begin : g_zero_check
    $error("vga_timing_generator: ACT and SYNC widths must be non-zero");
  end

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
  localparam logic [10:0] H_ACT_BEG  = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_ACT_END  = 11'(H_SYNC + H_BP + H_ACT);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_SYNC_END = 11'(V_SYNC);
  localparam logic [10:0] V_ACT_BEG  = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_ACT_END  = 11'(V_SYNC + V_BP + V_ACT);

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic        h_active;
  logic        v_active;
  logic        active;
  logic [23:0] rgb_q;

  // Raster position; disabling parks the raster at the frame origin.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 11'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  // NOTE: every combinational output gets a value on every path, so no latch is inferred.
  always_comb begin
    h_active = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
    v_active = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
    active   = en && h_active && v_active;
  end

  assign pix_ready = active;

  // Video outputs lag the raster by one cycle; all of them share that single stage.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      rgb_q       <= '0;
      frame_start <= 1'b0;
    end else if (!en) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      rgb_q       <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= !(h_cnt < H_SYNC_END);
      vsync       <= !(v_cnt < V_SYNC_END);
      de          <= active;
      rgb_q       <= (active && pix_valid) ? pix_rgb : '0;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  assign {r, g, b} = rgb_q;

  // A new underflow takes priority over a simultaneous clear.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      underflow <= 1'b0;
    end else if (active && !pix_valid) begin
      underflow <= 1'b1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Self-checking bench for vga_timing_generator using a small raster and a
// position-based reference model (frame position -> expected outputs).
module tb_vga_timing_generator;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FT = HT * VT;
  localparam logic [28:0] RST_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0};

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [23:0] pix_rgb;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  r, g, b;
  logic        hsync, vsync, de, frame_start, underflow, underflow_clr;

  int          checks = 0;
  int          errors = 0;
  int          pos;
  logic        uf_m;
  logic [28:0] exp_vec;
  logic        exp_ready;
  logic        obs_ready;
  logic [28:0] obs_vec;

  assign obs_vec = {hsync, vsync, de, frame_start, underflow, r, g, b};

  vga_timing_generator #(
    .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .pixel_clk    (clk),
    .rst          (rst),
    .en           (en),
    .pix_rgb      (pix_rgb),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .r            (r),
    .g            (g),
    .b            (b),
    .hsync        (hsync),
    .vsync        (vsync),
    .de           (de),
    .frame_start  (frame_start),
    .underflow    (underflow),
    .underflow_clr(underflow_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // Active video: line and pixel both inside their active windows.
  function automatic logic in_act(int p);
    int px = p % HT;
    int ln = p / HT;
    return (px >= HS + HB) && (px < HS + HB + HA) && (ln >= VS + VB) && (ln < VS + VB + VA);
  endfunction

  // Drive one cycle from a negedge, predict the outputs of the coming edge,
  // and return at the following negedge with the DUT outputs settled.
  task automatic tick(input logic e, input logic v, input logic c, input logic [23:0] d);
    int   px, ln;
    logic act;
    en = e; pix_valid = v; underflow_clr = c; pix_rgb = d;
    #1;
    act       = e && in_act(pos);
    exp_ready = act;
    obs_ready = pix_ready;
    if (act && !v) uf_m = 1'b1;
    else if (c)    uf_m = 1'b0;
    px = pos % HT;
    ln = pos / HT;
    if (e) exp_vec = {!(px < HS), !(ln < VS), act, pos == 0, uf_m, (act && v) ? d : 24'h0};
    else   exp_vec = {2'b11, 2'b00, uf_m, 24'h0};
    pos = e ? (pos + 1) % FT : 0;
    @(negedge clk);
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i <= FT && pos != target; i++) tick(1'b1, 1'b1, 1'b0, 24'($urandom()));
    checks++;
    if (pos != target) begin
      errors++;
      $display("FAIL run_to position got=%0d required=%0d", pos, target);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (obs_vec !== RST_VEC) begin
      errors++;
      $display("FAIL reset_initial got=%h required=%h", obs_vec, RST_VEC);
    end
    en = 1'b1; pix_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (obs_vec !== RST_VEC) begin
      errors++;
      $display("FAIL reset_held got=%h required=%h", obs_vec, RST_VEC);
    end
    rst = 1'b0;
    pos = 0;
    uf_m = 1'b0;
  endtask

  task automatic test_stream();
    int fs_n = 0;
    for (int f = 0; f < 2; f++) begin
      int cnt = 0, ready_n = 0, hs_low = 0, vs_low = 0, de_n = 0;
      logic [23:0] last = '0;
      for (int i = 0; i < FT; i++) begin
        tick(1'b1, 1'b1, 1'b0, 24'(cnt));
        checks++;
        if (obs_vec !== exp_vec || obs_ready !== exp_ready) begin
          errors++;
          $display("FAIL stream_cycle f=%0d i=%0d got=%h/%b required=%h/%b",
                   f, i, obs_vec, obs_ready, exp_vec, exp_ready);
        end
        if (obs_ready) begin cnt++; ready_n++; end
        if (de) begin last = {r, g, b}; de_n++; end
        if (!hsync) hs_low++;
        if (!vsync) vs_low++;
        if (frame_start) fs_n++;
      end
      checks++;
      if (ready_n != HA * VA) begin
        errors++;
        $display("FAIL stream_accepts got=%0d required=%0d", ready_n, HA * VA);
      end
      checks++;
      if (de_n != HA * VA) begin
        errors++;
        $display("FAIL stream_de_cycles got=%0d required=%0d", de_n, HA * VA);
      end
      checks++;
      if (last !== 24'(HA * VA - 1)) begin
        errors++;
        $display("FAIL stream_last_rgb got=%h required=%h", last, 24'(HA * VA - 1));
      end
      checks++;
      if (hs_low != HS * VT || vs_low != VS * HT) begin
        errors++;
        $display("FAIL stream_sync_low got=%0d/%0d required=%0d/%0d", hs_low, vs_low, HS * VT, VS * HT);
      end
    end
    checks++;
    if (fs_n != 2) begin
      errors++;
      $display("FAIL stream_frame_starts got=%0d required=2", fs_n);
    end
  endtask

  task automatic test_underflow();
    run_to((VS + VB + 1) * HT + HS + HB + 3);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b0, 24'hABCDEF);
      checks++;
      if (obs_vec !== exp_vec || !de || {r, g, b} !== 24'h0 || !underflow) begin
        errors++;
        $display("FAIL underflow_gap i=%0d got=%h required=%h", i, obs_vec, exp_vec);
      end
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1, 1'b0, 24'($urandom()));
      checks++;
      if (obs_vec !== exp_vec || !underflow) begin
        errors++;
        $display("FAIL underflow_sticky i=%0d got=%h required=%h", i, obs_vec, exp_vec);
      end
    end
    tick(1'b1, 1'b1, 1'b1, 24'($urandom()));
    checks++;
    if (obs_vec !== exp_vec || underflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_clear got=%h required=%h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_set_clr_collide();
    run_to((VS + VB) * HT + HS + HB);
    tick(1'b1, 1'b1, 1'b1, 24'($urandom()));
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL collide_preclear got=%b required=0", underflow);
    end
    tick(1'b1, 1'b0, 1'b1, 24'($urandom()));
    checks++;
    if (obs_vec !== exp_vec || underflow !== 1'b1) begin
      errors++;
      $display("FAIL collide_set_wins got=%h required=%h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_enable();
    run_to((VS + VB + 2) * HT + HS + HB + 2);
    tick(1'b0, 1'b1, 1'b0, 24'($urandom()));
    checks++;
    if (obs_ready !== 1'b0) begin
      errors++;
      $display("FAIL enable_ready_drop got=%b required=0", obs_ready);
    end
    checks++;
    if (obs_vec !== exp_vec || !hsync || !vsync || de) begin
      errors++;
      $display("FAIL enable_idle got=%h required=%h", obs_vec, exp_vec);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b0, 24'($urandom()));
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL enable_hold i=%0d got=%h required=%h", i, obs_vec, exp_vec);
      end
    end
    tick(1'b1, 1'b1, 1'b0, 24'($urandom()));
    checks++;
    if (obs_vec !== exp_vec || !frame_start || hsync || vsync) begin
      errors++;
      $display("FAIL enable_restart got=%h required=%h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_async_reset();
    run_to((VS + VB + 1) * HT + HS + HB + 1);
    tick(1'b1, 1'b0, 1'b0, 24'h123456);
    checks++;
    if (!de || !underflow) begin
      errors++;
      $display("FAIL areset_precondition de=%b underflow=%b required=1/1", de, underflow);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs_vec !== RST_VEC || pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL areset_immediate got=%h/%b required=%h/0", obs_vec, pix_ready, RST_VEC);
    end
    @(negedge clk);
    rst = 1'b0;
    pos = 0;
    uf_m = 1'b0;
    for (int i = 0; i < FT; i++) begin
      tick(1'b1, 1'b1, 1'b0, 24'($urandom()));
      checks++;
      if (obs_vec !== exp_vec || obs_ready !== exp_ready) begin
        errors++;
        $display("FAIL areset_restart i=%0d got=%h/%b required=%h/%b",
                 i, obs_vec, obs_ready, exp_vec, exp_ready);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3 * FT; i++) begin
      tick($urandom_range(0, 19) != 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 15) == 0, 24'($urandom()));
      checks++;
      if (obs_vec !== exp_vec || obs_ready !== exp_ready) begin
        errors++;
        $display("FAIL random_cycle i=%0d got=%h/%b required=%h/%b",
                 i, obs_vec, obs_ready, exp_vec, exp_ready);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pix_valid = 1'b0; pix_rgb = '0; underflow_clr = 1'b0;
    pos = 0; uf_m = 1'b0; exp_vec = RST_VEC; exp_ready = 1'b0; obs_ready = 1'b0;
    test_reset();
    test_stream();
    test_underflow();
    test_set_clr_collide();
    test_enable();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
